lz77_decoder: RTL

//  Downstream neighbour of the LZ77 encoder: consumes (offset, match_len, char_nxt) tokens and rebuilds the original byte stream.

---
 rtl/lz77_pkg.sv | 9 +
 rtl/lz77_hist_shreg.sv | 36 +++
 rtl/lz77_decoder.sv | 73 +++++++
 3 files changed

// File: rtl/lz77_pkg.sv
// lz77_pkg: constants and FSM state type shared by the LZ77 encoder and decoder
package lz77_pkg;
    localparam int LZ_DICT_DEPTH = 9;
    localparam int LZ_OFF_W = 4;
    localparam int LZ_LEN_W = 3;
    localparam int LZ_MAX_LEN = 2;
    localparam logic [7:0] LZ_TERM = 8'h24;
    typedef enum logic [1:0] {IDLE, COPY, LIT, DONE} state_e;
endpackage

// File: rtl/lz77_hist_shreg.sv
// lz77_hist_shreg: byte history shift register with saturating fill count and async read port
module lz77_hist_shreg
    import lz77_pkg::*;
#(
    parameter int DEPTH = LZ_DICT_DEPTH,
    parameter int IDX_W = LZ_OFF_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             shift_en,
    input  logic [7:0]       din,
    input  logic [IDX_W-1:0] rd_idx,
    output logic [7:0]       rd_data,
    output logic [IDX_W:0]   fill_nxt
);
    localparam logic [IDX_W:0] FULL = (IDX_W+1)'(DEPTH);
    logic [7:0]     hist_q [DEPTH];
    logic [IDX_W:0] fill_q, fill_d;
    always_comb begin
        fill_d = (shift_en && fill_q != FULL) ? fill_q + 1'b1 : fill_q;
        fill_nxt = fill_d;
        rd_data = ({1'b0, rd_idx} < FULL) ? hist_q[rd_idx] : 8'h00;
    end
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) hist_q[i] <= 8'h00;
            fill_q <= '0;
        end else begin
            fill_q <= fill_d;
            if (shift_en) begin
                hist_q[0] <= din;
                for (int i = 1; i < DEPTH; i++) hist_q[i] <= hist_q[i-1];
            end
        end
    end
endmodule

// File: rtl/lz77_decoder.sv
// lz77_decoder: rebuilds a byte stream from (offset, match_len, char_nxt) tokens, one byte per cycle
module lz77_decoder
    import lz77_pkg::*;
#(
    parameter int DICT_DEPTH = LZ_DICT_DEPTH,
    parameter int OFF_W = LZ_OFF_W,
    parameter int LEN_W = LZ_LEN_W,
    parameter int MAX_LEN = LZ_MAX_LEN
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             tok_valid,
    output logic             tok_ready,
    input  logic [OFF_W-1:0] offset,
    input  logic [LEN_W-1:0] match_len,
    input  logic [7:0]       char_nxt,
    output logic             char_valid,
    output logic [7:0]       char_out,
    output logic             finish,
    output logic             err
);
    state_e           state_q, state_d;
    logic [OFF_W-1:0] off_q;
    logic [LEN_W-1:0] cnt_q;
    logic [7:0]       lit_q, char_q, rd_data, din;
    logic             valid_q, finish_q, err_q, accept, shift_en, bad;
    logic [OFF_W:0]   fill_nxt;
    lz77_hist_shreg #(.DEPTH(DICT_DEPTH), .IDX_W(OFF_W)) u_hist (
        .clk(clk), .reset(reset), .shift_en(shift_en), .din(din),
        .rd_idx(off_q), .rd_data(rd_data), .fill_nxt(fill_nxt)
    );
    // Legality uses the fill after this edge's shift, so a token accepted in LIT sees the literal.
    always_comb begin
        tok_ready = reset && (state_q == IDLE || (state_q == LIT && lit_q != LZ_TERM));
        accept = tok_valid && tok_ready;
        shift_en = state_q == COPY || state_q == LIT;
        din = state_q == COPY ? rd_data : lit_q;
        bad = int'(match_len) > MAX_LEN || (match_len != '0 && {1'b0, offset} >= fill_nxt);
        state_d = state_q == COPY ? (cnt_q == LEN_W'(1) ? LIT : COPY)
                : state_q == DONE ? DONE
                : (state_q == LIT && lit_q == LZ_TERM) ? DONE
                : accept ? (match_len != '0 ? COPY : LIT)
                : IDLE;
    end
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
            off_q <= '0;
            cnt_q <= '0;
            lit_q <= 8'h00;
            char_q <= 8'h00;
            valid_q <= 1'b0;
            finish_q <= 1'b0;
            err_q <= 1'b0;
        end else begin
            state_q <= state_d;
            valid_q <= shift_en;
            if (shift_en) char_q <= din;
            if (state_q == COPY) cnt_q <= cnt_q - 1'b1;
            if (state_q == LIT && lit_q == LZ_TERM) finish_q <= 1'b1;
            if (accept) begin
                off_q <= offset;
                cnt_q <= match_len;
                lit_q <= char_nxt;
                err_q <= err_q | bad;
            end
        end
    end
    assign char_valid = valid_q;
    assign char_out = char_q;
    assign finish = finish_q;
    assign err = err_q;
endmodule
